// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - M-extension op codes, FSM state encoding and word-result helper.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  function automatic logic [63:0] sext_word(input logic [63:0] x);
    return {{32{x[31]}}, x[31:0]};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add (multiply) or trial-subtract (divide) iteration.
module muldiv_step #(
  parameter int XLEN = 64
) (
  input  logic              mul,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   divisor,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   top;
  logic [XLEN-1:0] diff;
  logic            fits;

  always_comb begin
    sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, divisor} : {(XLEN+1){1'b0}});
    // Shifted remainder can exceed XLEN bits, so compare on XLEN+1 bits.
    top  = acc[2*XLEN-1:XLEN-1];
    fits = (top >= {1'b0, divisor});
    diff = top[XLEN-1:0] - divisor;
    if (mul) begin
      acc_next = {sum, acc[XLEN-1:1]};
    end else if (fits) begin
      acc_next = {diff, acc[XLEN-2:0], 1'b1};
    end else begin
      acc_next = {acc[2*XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV64 M-extension multiply/divide controller.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [2:0]       funct3_i,
  input  logic             word_i,
  input  logic [XLEN-1:0]  operand1_i,
  input  logic [XLEN-1:0]  operand2_i,
  input  logic [4:0]       rd_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [XLEN-1:0]  result_o,
  output logic [4:0]       rd_o,
  output logic             rf_wen_o
);

  md_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc, acc_next, prod;
  logic [XLEN-1:0]   b_q, pend_res, res_q;
  logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, zdiv_res, sel, fin_res;
  logic [2:0]        f3_q;
  logic [4:0]        rd_pend, rd_q;
  logic              word_q, neg_a_q, neg_b_q;
  logic              word_signed, neg_a_in, neg_b_in, zero_div;

  always_comb begin
    word_signed = !(funct3_i == MD_DIVU || funct3_i == MD_REMU);
    a_ext = operand1_i;
    b_ext = operand2_i;
    if (word_i) begin
      a_ext = word_signed ? sext_word(operand1_i) : {32'b0, operand1_i[31:0]};
      b_ext = word_signed ? sext_word(operand2_i) : {32'b0, operand2_i[31:0]};
    end
    neg_a_in = (funct3_i inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) && a_ext[XLEN-1];
    neg_b_in = (funct3_i inside {MD_MULH, MD_DIV, MD_REM}) && b_ext[XLEN-1];
    a_mag    = neg_a_in ? -a_ext : a_ext;
    b_mag    = neg_b_in ? -b_ext : b_ext;
    zero_div = funct3_i[2] && (b_ext == '0);
    zdiv_res = funct3_i[1] ? a_ext : '1;
    if (word_i) zdiv_res = sext_word(zdiv_res);
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .mul      (!f3_q[2]),
    .acc      (acc),
    .divisor  (b_q),
    .acc_next (acc_next)
  );

  // Sign fix on the final iteration's output; remainder follows the dividend.
  always_comb begin
    prod = (neg_a_q ^ neg_b_q) ? -acc_next : acc_next;
    if (!f3_q[2]) begin
      sel = (f3_q == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else if (f3_q[1]) begin
      sel = neg_a_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    end else begin
      sel = (neg_a_q ^ neg_b_q) ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    end
    fin_res = word_q ? sext_word(sel) : sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      acc      <= '0;
      b_q      <= '0;
      f3_q     <= '0;
      word_q   <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      rd_pend  <= '0;
      pend_res <= '0;
      res_q    <= '0;
      rd_q     <= '0;
    end else if (flush_i) begin
      state <= MD_IDLE;
    end else begin
      case (state)
        MD_IDLE: if (valid_i) begin
          f3_q    <= funct3_i;
          word_q  <= word_i;
          rd_pend <= rd_i;
          neg_a_q <= neg_a_in;
          neg_b_q <= neg_b_in;
          cnt     <= '0;
          acc     <= {{XLEN{1'b0}}, a_mag};
          b_q     <= b_mag;
          if (zero_div) begin
            pend_res <= zdiv_res;
            state    <= MD_DONE;
          end else begin
            state <= MD_CALC;
          end
        end
        MD_CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            pend_res <= fin_res;
            state    <= MD_DONE;
          end
        end
        MD_DONE: begin
          res_q <= pend_res;
          rd_q  <= rd_pend;
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  // A flush in DONE cancels the pulse and keeps the previously committed result visible.
  assign busy_o   = (state != MD_IDLE);
  assign done_o   = (state == MD_DONE) && !flush_i;
  assign result_o = done_o ? pend_res : res_q;
  assign rd_o     = done_o ? rd_pend : rd_q;
  assign rf_wen_o = done_o && (rd_o != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized and directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic        word_i = 1'b0;
  logic [63:0] operand1_i = '0;
  logic [63:0] operand2_i = '0;
  logic [4:0]  rd_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o, done_o, rf_wen_o;
  logic [63:0] result_o;
  logic [4:0]  rd_o;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] last_res = '0;
  logic [4:0]  last_rd = '0;

  muldiv_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .funct3_i   (funct3_i),
    .word_i     (word_i),
    .operand1_i (operand1_i),
    .operand2_i (operand2_i),
    .rd_i       (rd_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .rd_o       (rd_o),
    .rf_wen_o   (rf_wen_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural RISC-V results from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [2:0] f3, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] p;
    logic [31:0] a32, b32, r32;
    int          sa32, sb32;
    longint      sa, sb;
    logic [63:0] r;
    r = '0;
    if (w) begin
      a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
      r32 = '0;
      case (f3)
        3'b100: if (b32 == 0) r32 = '1;
                else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = a32;
                else r32 = sa32 / sb32;
        3'b110: if (b32 == 0) r32 = a32;
                else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = '0;
                else r32 = sa32 % sb32;
        3'b101: if (b32 == 0) r32 = '1; else r32 = a32 / b32;
        3'b111: if (b32 == 0) r32 = a32; else r32 = a32 % b32;
        default: r32 = a32 * b32;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      sa = a; sb = b;
      case (f3)
        3'b000: r = a * b;
        3'b001: begin p = $signed(a) * $signed(b); r = p[127:64]; end
        3'b010: begin p = $signed({{64{a[63]}}, a}) * $signed({64'b0, b}); r = p[127:64]; end
        3'b011: begin p = {64'b0, a} * {64'b0, b}; r = p[127:64]; end
        3'b100: if (b == 0) r = '1;
                else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
                else r = sa / sb;
        3'b110: if (b == 0) r = a;
                else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
                else r = sa % sb;
        3'b101: if (b == 0) r = '1; else r = a / b;
        default: if (b == 0) r = a; else r = a % b;
      endcase
    end
    return r;
  endfunction

  function automatic int exp_latency(input logic [2:0] f3, input logic w, input logic [63:0] b);
    logic zero;
    zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    return (f3[2] && zero) ? 1 : 65;
  endfunction

  task automatic start_op(input logic [2:0] f3, input logic w,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    @(negedge clk);
    funct3_i = f3; word_i = w; operand1_i = a; operand2_i = b; rd_i = rd;
    valid_i = 1'b1;
  endtask

  // valid_i stays high through the whole operation, as a stalled requester would.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    logic [63:0] exp;
    int          n;
    logic        busy_ok;
    exp = model(f3, w, a, b);
    start_op(f3, w, a, b, rd);
    n = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (!busy_o) busy_ok = 1'b0;
    end while (!done_o && n < 200);
    check({tag, " latency"}, 64'(n), 64'(exp_latency(f3, w, b)));
    check({tag, " result"}, result_o, exp);
    check({tag, " rd"}, 64'(rd_o), 64'(rd));
    check({tag, " rf_wen"}, 64'(rf_wen_o), 64'(rd != 5'd0));
    check({tag, " busy"}, 64'(busy_ok), 64'd1);
    valid_i = 1'b0;
    @(negedge clk);
    check({tag, " idle"}, {62'd0, busy_o, done_o}, 64'd0);
    check({tag, " hold"}, result_o, exp);
    last_res = exp;
    last_rd  = rd;
  endtask

  initial begin
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a, b;
    int          n;
    logic        seen_done;

    #12;
    check("reset outs", {result_o[62:0], busy_o}, 64'd0);
    check("reset flags", {59'd0, rd_o}, 64'd0);
    check("reset done", {62'd0, done_o, rf_wen_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul 7*-3", 3'b000, 1'b0, 64'd7, -64'sd3, 5'd1);
    run_op("mulhu max", 3'b011, 1'b0, '1, '1, 5'd2);
    run_op("mulh -1*-1", 3'b001, 1'b0, '1, '1, 5'd3);
    run_op("mulhsu -1*2", 3'b010, 1'b0, '1, 64'd2, 5'd4);
    run_op("div -7/2", 3'b100, 1'b0, -64'sd7, 64'd2, 5'd5);
    run_op("rem -7/2", 3'b110, 1'b0, -64'sd7, 64'd2, 5'd6);
    run_op("divu 100/7", 3'b101, 1'b0, 64'd100, 64'd7, 5'd7);
    run_op("remu 100/7", 3'b111, 1'b0, 64'd100, 64'd7, 5'd8);
    run_op("div ovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd9);
    run_op("rem ovf", 3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd10);
    run_op("div 5/0", 3'b100, 1'b0, 64'd5, 64'd0, 5'd11);
    run_op("rem 5/0", 3'b110, 1'b0, 64'd5, 64'd0, 5'd12);
    run_op("divw ovf", 3'b100, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd13);
    run_op("mulw", 3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd14);
    run_op("divuw", 3'b101, 1'b1, 64'hFFFF_FFFF, 64'd1, 5'd15);
    run_op("remuw /0", 3'b111, 1'b1, 64'h1_8000_0001, 64'h5_0000_0000, 5'd16);
    run_op("rd0", 3'b000, 1'b0, 64'd9, 64'd9, 5'd0);

    // Flush in CALC: no completion ever, old result stays.
    start_op(3'b100, 1'b0, 64'd1000, 64'd3, 5'd20);
    for (int i = 0; i < 10; i++) @(negedge clk);
    flush_i = 1'b1; valid_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush idle", 64'(busy_o), 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done_o || busy_o) seen_done = 1'b1;
    end
    check("flush no done", 64'(seen_done), 64'd0);
    check("flush result", result_o, last_res);
    check("flush rd", 64'(rd_o), 64'(last_rd));

    // Flush during the DONE cycle suppresses the pulse.
    start_op(3'b101, 1'b0, 64'd50, 64'd5, 5'd21);
    n = 0;
    do begin @(negedge clk); n++; end while (!done_o && n < 200);
    check("dflush latency", 64'(n), 64'd65);
    flush_i = 1'b1; valid_i = 1'b0;
    #1;
    check("dflush done", {62'd0, done_o, rf_wen_o}, 64'd0);
    check("dflush result", result_o, last_res);
    @(negedge clk);
    flush_i = 1'b0;
    check("dflush idle", 64'(busy_o), 64'd0);
    check("dflush rd", 64'(rd_o), 64'(last_rd));

    for (int k = 0; k < 30; k++) begin
      f3 = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      if (w && f3 inside {3'b001, 3'b010, 3'b011}) f3 = 3'b000;
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = 64'($urandom_range(0, 15));
        2: a = 64'h8000_0000_0000_0000;
        3: b = w ? {32'hABCD_0000, 32'd0} : '1;
        default: ;
      endcase
      run_op($sformatf("rand%0d f3=%0d w=%0d", k, f3, w), f3, w, a, b, 5'($urandom_range(0, 31)));
    end

    // Asynchronous reset in the middle of an operation.
    start_op(3'b000, 1'b0, 64'd123, 64'd456, 5'd22);
    for (int i = 0; i < 30; i++) @(negedge clk);
    valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst busy", {62'd0, busy_o, done_o}, 64'd0);
    check("rst result", result_o, 64'd0);
    check("rst rd", 64'(rd_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o || busy_o) seen_done = 1'b1;
    end
    check("rst no done", 64'(seen_done), 64'd0);
    run_op("post rst", 3'b110, 1'b0, -64'sd100, 64'd7, 5'd23);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
